// File: rtl/tt_um_emern_scene_loader.sv
// SPI-slave scene register file feeding the pixel core with polygon, color and enable data.
// Define SCENE_LOADER_DBUF_EN for shadow/active double buffering with frame-aligned commit.
module tt_um_emern_scene_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  input  logic        frame_start,
  output logic [1:0]  cmp_en,
  output logic [5:0]  background_color,
  output logic [11:0] poly_color,
  output logic [13:0] v0_x,
  output logic [13:0] v1_x,
  output logic [13:0] v2_x,
  output logic [11:0] v0_y,
  output logic [11:0] v1_y,
  output logic [11:0] v2_y,
  output logic [5:0]  poly_depth,
  output logic        commit_pending
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_POLY   = 3'd2;
  localparam logic [2:0] ST_CTRL   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_prev, cs_prev;
  logic [2:0]  state;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic [6:0]  shift;
  logic [39:0] stage;
  logic        poly_sel;

  // NOTE: the cs_n synchronizer resets low, so cs_n must be seen high before a
  // falling edge can open a transfer; a reset mid-transfer drops that transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  logic        cs_n_s, sclk_rise, cs_fall, byte_done;
  logic [7:0]  byte_val;
  logic [47:0] record;
  logic        poly_wr, ctrl_wr;

  assign cs_n_s    = cs_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign cs_fall   = cs_prev & ~cs_n_s;
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_n_s && (state != ST_IDLE);
  assign byte_val  = {shift, mosi_sync[1]};
  assign record    = {stage, byte_val};
  assign poly_wr   = byte_done && (state == ST_POLY) && (byte_cnt == 3'd5);
  assign ctrl_wr   = byte_done && (state == ST_CTRL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      stage    <= '0;
      poly_sel <= 1'b0;
    end else if (cs_n_s) begin
      state <= ST_IDLE;
    end else if (cs_fall) begin
      state    <= ST_CMD;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (state != ST_IDLE && sclk_rise) begin
      shift   <= {shift[5:0], mosi_sync[1]};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        case (state)
          ST_CMD: begin
            case (byte_val)
              8'h80:   begin state <= ST_POLY; poly_sel <= 1'b0; end
              8'h81:   begin state <= ST_POLY; poly_sel <= 1'b1; end
              8'h40:   state <= ST_CTRL;
              default: state <= ST_IGNORE;
            endcase
          end
          ST_POLY: begin
            stage    <= {stage[31:0], byte_val};
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd5) state <= ST_IGNORE;
          end
          ST_CTRL: state <= ST_IGNORE;
          default: state <= ST_IGNORE;
        endcase
      end
    end
  end

  // Write-target registers: the shadow copy when double buffered, else the outputs.
  logic [1:0]  sc_cmp_en;
  logic [5:0]  sc_bg;
  logic [11:0] sc_color;
  logic [13:0] sc_v0_x, sc_v1_x, sc_v2_x;
  logic [11:0] sc_v0_y, sc_v1_y, sc_v2_y;
  logic [5:0]  sc_depth;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_cmp_en <= '0;
      sc_bg     <= '0;
      sc_color  <= '0;
      sc_v0_x   <= '0;
      sc_v1_x   <= '0;
      sc_v2_x   <= '0;
      sc_v0_y   <= '0;
      sc_v1_y   <= '0;
      sc_v2_y   <= '0;
      sc_depth  <= '0;
    end else begin
      if (poly_wr) begin
        if (poly_sel) begin
          sc_v0_x[13:7]    <= record[47:41];
          sc_v0_y[11:6]    <= record[40:35];
          sc_v1_x[13:7]    <= record[34:28];
          sc_v1_y[11:6]    <= record[27:22];
          sc_v2_x[13:7]    <= record[21:15];
          sc_v2_y[11:6]    <= record[14:9];
          sc_color[11:6]   <= record[8:3];
          sc_depth[2:0]    <= record[2:0];
        end else begin
          sc_v0_x[6:0]     <= record[47:41];
          sc_v0_y[5:0]     <= record[40:35];
          sc_v1_x[6:0]     <= record[34:28];
          sc_v1_y[5:0]     <= record[27:22];
          sc_v2_x[6:0]     <= record[21:15];
          sc_v2_y[5:0]     <= record[14:9];
          sc_color[5:0]    <= record[8:3];
          sc_depth[5:3]    <= record[2:0];
        end
      end
      if (ctrl_wr) begin
        sc_cmp_en <= byte_val[7:6];
        sc_bg     <= byte_val[5:0];
      end
    end
  end

`ifdef SCENE_LOADER_DBUF_EN
  logic commit_req;
  assign commit_req = byte_done && (state == ST_CMD) && (byte_val == 8'hC0);

  // The swap reads the shadow before any same-cycle write lands; a request
  // arriving with frame_start only arms the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_en           <= '0;
      background_color <= '0;
      poly_color       <= '0;
      v0_x             <= '0;
      v1_x             <= '0;
      v2_x             <= '0;
      v0_y             <= '0;
      v1_y             <= '0;
      v2_y             <= '0;
      poly_depth       <= '0;
      commit_pending   <= 1'b0;
    end else begin
      if (frame_start && commit_pending) begin
        cmp_en           <= sc_cmp_en;
        background_color <= sc_bg;
        poly_color       <= sc_color;
        v0_x             <= sc_v0_x;
        v1_x             <= sc_v1_x;
        v2_x             <= sc_v2_x;
        v0_y             <= sc_v0_y;
        v1_y             <= sc_v1_y;
        v2_y             <= sc_v2_y;
        poly_depth       <= sc_depth;
        commit_pending   <= 1'b0;
      end
      if (commit_req) commit_pending <= 1'b1;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  assign cmp_en           = sc_cmp_en;
  assign background_color = sc_bg;
  assign poly_color       = sc_color;
  assign v0_x             = sc_v0_x;
  assign v1_x             = sc_v1_x;
  assign v2_x             = sc_v2_x;
  assign v0_y             = sc_v0_y;
  assign v1_y             = sc_v1_y;
  assign v2_y             = sc_v2_y;
  assign poly_depth       = sc_depth;
  assign commit_pending   = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_emern_scene_loader.sv
// Directed bench for tt_um_emern_scene_loader; follows SCENE_LOADER_DBUF_EN the same way the RTL does.
module tb_tt_um_emern_scene_loader;

`ifdef SCENE_LOADER_DBUF_EN
  localparam logic [31:0] EXP_PEND   = 32'd1;
  localparam logic [31:0] EXP_DIRECT = 32'd0;
`else
  localparam logic [31:0] EXP_PEND   = 32'd0;
  localparam logic [31:0] EXP_DIRECT = 32'd1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, spi_sclk, spi_cs_n, spi_mosi, frame_start;
  logic [1:0]  cmp_en;
  logic [5:0]  background_color;
  logic [11:0] poly_color;
  logic [13:0] v0_x, v1_x, v2_x;
  logic [11:0] v0_y, v1_y, v2_y;
  logic [5:0]  poly_depth;
  logic        commit_pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tt_um_emern_scene_loader dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .frame_start(frame_start), .cmp_en(cmp_en),
    .background_color(background_color), .poly_color(poly_color),
    .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x), .v0_y(v0_y), .v1_y(v1_y),
    .v2_y(v2_y), .poly_depth(poly_depth), .commit_pending(commit_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    tick(2);
    spi_sclk = 1'b1;
    tick(4);
    spi_sclk = 1'b0;
    tick(2);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(2);
  endtask

  // Commit then frame boundary; harmless when the design writes outputs directly.
  task automatic commit_swap();
    cs_begin();
    spi_byte(8'hC0);
    cs_end();
    pulse_frame();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmp_en"}, 32'(cmp_en), 32'd0);
    check({tag, "_bg"},     32'(background_color), 32'd0);
    check({tag, "_color"},  32'(poly_color), 32'd0);
    check({tag, "_v0_x"},   32'(v0_x), 32'd0);
    check({tag, "_v1_x"},   32'(v1_x), 32'd0);
    check({tag, "_v2_x"},   32'(v2_x), 32'd0);
    check({tag, "_v0_y"},   32'(v0_y), 32'd0);
    check({tag, "_v1_y"},   32'(v1_y), 32'd0);
    check({tag, "_v2_y"},   32'(v2_y), 32'd0);
    check({tag, "_depth"},  32'(poly_depth), 32'd0);
    check({tag, "_pend"},   32'(commit_pending), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    frame_start = 1'b0;
    tick(5);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(3);

    // Polygon A record; the final bit is clocked by hand to time the write.
    cs_begin();
    spi_byte(8'h80);
    spi_byte(8'h02);
    spi_byte(8'h10);
    spi_byte(8'h31);
    spi_byte(8'h02);
    spi_byte(8'h8D);
    for (int i = 7; i >= 1; i--) spi_bit(1'(8'hFD >> i));
    spi_mosi = 1'b1;
    tick(2);
    spi_sclk = 1'b1;
    tick(2);
    check("poly_pre_write", 32'(v0_x), 32'd0);
    tick(1);
    check("poly_post_write", 32'(v0_x), EXP_DIRECT);
    tick(3);
    spi_sclk = 1'b0;
    tick(2);
    cs_end();

    cs_begin();
    spi_byte(8'hC0);
    cs_end();
    check("pend_after_c0", 32'(commit_pending), EXP_PEND);
    check("v0_y_before_frame", 32'(v0_y), 32'(2 * EXP_DIRECT));
    pulse_frame();
    check("polyA_v0_x", 32'(v0_x), 32'h0001);
    check("polyA_v0_y", 32'(v0_y), 32'h002);
    check("polyA_v1_x", 32'(v1_x), 32'h0003);
    check("polyA_v1_y", 32'(v1_y), 32'h004);
    check("polyA_v2_x", 32'(v2_x), 32'h0005);
    check("polyA_v2_y", 32'(v2_y), 32'h006);
    check("polyA_color", 32'(poly_color), 32'h03F);
    check("polyA_depth", 32'(poly_depth), 32'h28);
    check("pend_after_swap", 32'(commit_pending), 32'd0);

    // Control byte 0xEA: enables 2'b11, background 0x2A.
    cs_begin();
    spi_byte(8'h40);
    spi_byte(8'hEA);
    cs_end();
    commit_swap();
    check("ctrl_cmp_en", 32'(cmp_en), 32'd3);
    check("ctrl_bg", 32'(background_color), 32'h2A);

    // Truncated B record and truncated control byte leave everything unchanged.
    cs_begin();
    spi_byte(8'h81);
    spi_byte(8'hFF);
    spi_byte(8'hFF);
    spi_byte(8'hFF);
    cs_end();
    cs_begin();
    spi_byte(8'h40);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    cs_end();
    commit_swap();
    check("trunc_v0_x", 32'(v0_x), 32'h0001);
    check("trunc_color", 32'(poly_color), 32'h03F);
    check("trunc_depth", 32'(poly_depth), 32'h28);
    check("trunc_cmp_en", 32'(cmp_en), 32'd3);

    // Full B record with the same payload lands in the upper fields.
    cs_begin();
    spi_byte(8'h81);
    spi_byte(8'h02);
    spi_byte(8'h10);
    spi_byte(8'h31);
    spi_byte(8'h02);
    spi_byte(8'h8D);
    spi_byte(8'hFD);
    cs_end();
    commit_swap();
    check("polyB_v0_x", 32'(v0_x), 32'h0081);
    check("polyB_v0_y", 32'(v0_y), 32'h082);
    check("polyB_v1_x", 32'(v1_x), 32'h0183);
    check("polyB_v1_y", 32'(v1_y), 32'h104);
    check("polyB_v2_x", 32'(v2_x), 32'h0285);
    check("polyB_v2_y", 32'(v2_y), 32'h186);
    check("polyB_color", 32'(poly_color), 32'hFFF);
    check("polyB_depth", 32'(poly_depth), 32'h2D);

`ifdef SCENE_LOADER_DBUF_EN
    // Commit completing in the frame_start cycle is deferred one frame.
    cs_begin();
    spi_byte(8'h40);
    spi_byte(8'h00);
    cs_end();
    cs_begin();
    for (int i = 7; i >= 1; i--) spi_bit(1'(8'hC0 >> i));
    spi_mosi = 1'b0;
    tick(2);
    spi_sclk = 1'b1;
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
    check("simul_pend", 32'(commit_pending), 32'd1);
    check("simul_no_swap", 32'(cmp_en), 32'd3);
    tick(1);
    spi_sclk = 1'b0;
    tick(2);
    cs_end();
    check("simul_pend_hold", 32'(commit_pending), 32'd1);
    pulse_frame();
    check("simul_swap", 32'(cmp_en), 32'd0);
    check("simul_pend_clr", 32'(commit_pending), 32'd0);
`endif

    // Reset mid-transfer with sclk toggling, then bits with cs still low are ignored.
    cs_begin();
    spi_bit(1'b0);
    spi_bit(1'b1);
    spi_bit(1'b0);
    rst_n = 1'b0;
    spi_bit(1'b1);
    spi_bit(1'b1);
    check_all_zero("midrst");
    rst_n = 1'b1;
    tick(2);
    spi_byte(8'h40);
    spi_byte(8'hFF);
    check("post_rst_ignored", 32'(cmp_en), 32'd0);
    cs_end();
    cs_begin();
    spi_byte(8'h40);
    spi_byte(8'hD5);
    cs_end();
    commit_swap();
    check("post_rst_cmp_en", 32'(cmp_en), 32'd3);
    check("post_rst_bg", 32'(background_color), 32'h15);
    check("final_pend", 32'(commit_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
